inimigo_controlador: RTL and testbench

- Sequences enemy sprite motion for the game: generates a movement tick from CLOCK_50 and runs a behaviour FSM (patrol, chase, hit-stun).
- Outputs the enemy bounding box (x, y, largura, altura) to the renderer and collision logic.
- Replaces the static enemy position block.
- Sits between the player position/collision logic and the VGA draw stage.

---
 rtl/inimigo_pkg.sv | 39 +++
 rtl/inimigo_controlador_gerador_tick.sv | 25 ++
 rtl/inimigo_controlador.sv | 114 +++++++++++
 tb/tb_inimigo_controlador.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/inimigo_pkg.sv
// Shared enemy/controller definitions: FSM encodings, screen limits and
// the per-axis approach step used while chasing.
package inimigo_pkg;

  typedef enum logic [1:0] {
    PATRULHA = 2'd0,
    PERSEGUE = 2'd1,
    ATINGIDO = 2'd2
  } estado_t;

  localparam int X_MAX   = 640;
  localparam int Y_MAX   = 480;
  localparam int TAM_PAD = 30;
  localparam int VEL_PAD = 2;

  function automatic logic signed [10:0] abs11(input logic signed [10:0] v);
    return v[10] ? -v : v;
  endfunction

  // Step toward alvo by passo, snapping when closer than one step, then clamp to [0, limite].
  function automatic logic [9:0] aproxima(input logic [9:0] atual,
                                          input logic [9:0] alvo,
                                          input logic signed [10:0] passo,
                                          input logic signed [10:0] limite);
    logic signed [10:0] d;
    logic signed [10:0] n;
    d = $signed({1'b0, alvo}) - $signed({1'b0, atual});
    if (abs11(d) >= passo)
      n = d[10] ? $signed({1'b0, atual}) - passo : $signed({1'b0, atual}) + passo;
    else
      n = $signed({1'b0, alvo});
    if (n[10])
      n = '0;
    else if (n > limite)
      n = limite;
    return n[9:0];
  endfunction

endpackage

// File: rtl/inimigo_controlador_gerador_tick.sv
// Movement tick generator: free-running divider that freezes while paused.
module gerador_tick #(
  parameter int TICK_DIV = 833333
) (
  input  logic CLOCK_50,
  input  logic i_rst,
  input  logic i_pausa,
  output logic o_tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] ULTIMO = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  assign o_tick = ~i_pausa & (r_cnt == ULTIMO);

  always_ff @(posedge CLOCK_50 or posedge i_rst) begin
    if (i_rst)
      r_cnt <= '0;
    else if (!i_pausa)
      r_cnt <= (r_cnt == ULTIMO) ? '0 : r_cnt + CW'(1);
  end

endmodule

// File: rtl/inimigo_controlador.sv
// Enemy behaviour controller: patrol / chase / hit-stun FSM advancing on the
// movement tick, publishing the enemy bounding box.
module inimigo_controlador
  import inimigo_pkg::*;
#(
  parameter int TICK_DIV = 833333,
  parameter int VEL      = VEL_PAD,
  parameter int RAIO     = 120,
  parameter int COOLDOWN = 30,
  parameter int X_INI    = 300,
  parameter int Y_INI    = 300,
  parameter int TAM      = TAM_PAD
) (
  input  logic       CLOCK_50,
  input  logic       resetInimigo,
  input  logic       pausa,
  input  logic [9:0] jogador_x,
  input  logic [9:0] jogador_y,
  input  logic       colisao,
  output logic [9:0] largura,
  output logic [9:0] altura,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       direcao,
  output logic [1:0] estado,
  output logic       tick
);

  localparam int CDW = $clog2(COOLDOWN + 1);
  localparam logic signed [10:0] S_VEL  = 11'(VEL);
  localparam logic signed [10:0] S_RAIO = 11'(RAIO);
  localparam logic signed [10:0] X_LIM  = 11'(X_MAX - TAM);
  localparam logic signed [10:0] Y_LIM  = 11'(Y_MAX - TAM);
  localparam logic [9:0]         X_LIM10 = 10'(X_MAX - TAM);

  logic [9:0]         r_x, r_y;
  logic               r_dir;
  estado_t            r_estado;
  logic [CDW-1:0]     r_cd;
  logic               w_tick;
  logic signed [10:0] w_dx, w_dy, w_px;
  logic               w_perto;

  gerador_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .CLOCK_50(CLOCK_50),
    .i_rst   (resetInimigo),
    .i_pausa (pausa),
    .o_tick  (w_tick)
  );

  assign w_dx    = $signed({1'b0, jogador_x}) - $signed({1'b0, r_x});
  assign w_dy    = $signed({1'b0, jogador_y}) - $signed({1'b0, r_y});
  assign w_perto = (abs11(w_dx) < S_RAIO) && (abs11(w_dy) < S_RAIO);
  assign w_px    = $signed({1'b0, r_x}) + (r_dir ? -S_VEL : S_VEL);

  // A tick that changes state does not also move the enemy; collisions
  // override any tick work in the same cycle.
  always_ff @(posedge CLOCK_50 or posedge resetInimigo) begin
    if (resetInimigo) begin
      r_x      <= 10'(X_INI);
      r_y      <= 10'(Y_INI);
      r_dir    <= 1'b0;
      r_estado <= PATRULHA;
      r_cd     <= '0;
    end else if (!pausa) begin
      if (colisao) begin
        r_estado <= ATINGIDO;
        r_cd     <= CDW'(COOLDOWN);
      end else begin
        case (r_estado)
          PATRULHA: if (w_tick) begin
            if (w_perto) begin
              r_estado <= PERSEGUE;
            end else if (w_px >= X_LIM) begin
              r_x   <= X_LIM10;
              r_dir <= 1'b1;
            end else if (w_px[10] || w_px == '0) begin
              r_x   <= '0;
              r_dir <= 1'b0;
            end else begin
              r_x <= w_px[9:0];
            end
          end
          PERSEGUE: if (w_tick) begin
            if (!w_perto) begin
              r_estado <= PATRULHA;
            end else begin
              r_x <= aproxima(r_x, jogador_x, S_VEL, X_LIM);
              r_y <= aproxima(r_y, jogador_y, S_VEL, Y_LIM);
            end
          end
          ATINGIDO: if (w_tick) begin
            if (r_cd <= CDW'(1)) begin
              r_cd     <= '0;
              r_estado <= PATRULHA;
            end else begin
              r_cd <= r_cd - CDW'(1);
            end
          end
          default: r_estado <= PATRULHA;
        endcase
      end
    end
  end

  assign largura = 10'(TAM);
  assign altura  = 10'(TAM);
  assign x       = r_x;
  assign y       = r_y;
  assign direcao = r_dir;
  assign estado  = r_estado;
  assign tick    = w_tick;

endmodule

// File: tb/tb_inimigo_controlador.sv
// Randomized bench for inimigo_controlador against a tick-level behavioural model.
module tb_inimigo_controlador;

  localparam int TD  = 4;
  localparam int CD  = 3;
  localparam int VEL = 2;
  localparam int XL  = 610;
  localparam int YL  = 450;

  logic       CLOCK_50 = 1'b0;
  logic       resetInimigo = 1'b0;
  logic       pausa = 1'b0;
  logic [9:0] jogador_x = '0;
  logic [9:0] jogador_y = '0;
  logic       colisao = 1'b0;
  logic [9:0] largura, altura, x, y;
  logic       direcao;
  logic [1:0] estado;
  logic       tick;

  inimigo_controlador #(.TICK_DIV(TD), .COOLDOWN(CD)) dut (
    .CLOCK_50(CLOCK_50), .resetInimigo(resetInimigo), .pausa(pausa),
    .jogador_x(jogador_x), .jogador_y(jogador_y), .colisao(colisao),
    .largura(largura), .altura(altura), .x(x), .y(y),
    .direcao(direcao), .estado(estado), .tick(tick)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_chk = 0;
  int n_err = 0;

  // model: st 0 patrol, 1 chase, 2 stun; cyc counts cycles since last tick
  int mx, my, mdir, mst, mcyc, mcd;
  bit mticked;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int iabs(input int v);
    return v < 0 ? -v : v;
  endfunction

  function automatic int aprox(input int c, input int t, input int lim);
    int n;
    if (t - c >= VEL) n = c + VEL;
    else if (c - t >= VEL) n = c - VEL;
    else n = t;
    return n < 0 ? 0 : (n > lim ? lim : n);
  endfunction

  function automatic bit near();
    return iabs(int'(jogador_x) - mx) < 120 && iabs(int'(jogador_y) - my) < 120;
  endfunction

  function automatic bit tick_due();
    return (mcyc == TD - 1) && !pausa;
  endfunction

  task automatic model_reset();
    mx = 300; my = 300; mdir = 0; mst = 0; mcyc = 0; mcd = 0;
  endtask

  task automatic model_edge();
    bit t;
    int nx;
    t = tick_due();
    mticked = t;
    if (pausa) return;
    mcyc = (mcyc + 1) % TD;
    if (colisao) begin
      mst = 2; mcd = CD;
    end else if (t) begin
      if (mst == 0) begin
        if (near()) mst = 1;
        else begin
          nx = mdir ? mx - VEL : mx + VEL;
          if (nx >= XL) begin nx = XL; mdir = 1; end
          else if (nx <= 0) begin nx = 0; mdir = 0; end
          mx = nx;
        end
      end else if (mst == 1) begin
        if (!near()) mst = 0;
        else begin
          mx = aprox(mx, int'(jogador_x), XL);
          my = aprox(my, int'(jogador_y), YL);
        end
      end else begin
        mcd--;
        if (mcd <= 0) begin mcd = 0; mst = 0; end
      end
    end
  endtask

  // Called at a negedge: drive, check tick, clock, check registered outputs.
  task automatic step(input bit p, input bit c);
    pausa = p; colisao = c;
    #1 chk("tick", int'(tick), int'(tick_due()));
    @(posedge CLOCK_50);
    model_edge();
    @(negedge CLOCK_50);
    chk("x", int'(x), mx);
    chk("y", int'(y), my);
    chk("estado", int'(estado), mst);
    chk("direcao", int'(direcao), mdir);
    colisao = 1'b0;
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      int guard = 0;
      do begin step(1'b0, 1'b0); guard++; end while (!mticked && guard < 4 * TD);
      if (!mticked) chk("tick_timeout", 0, 1);
    end
  endtask

  task automatic do_reset(input int jx, input int jy);
    jogador_x = 10'(jx); jogador_y = 10'(jy);
    #2 resetInimigo = 1'b1;
    #1;
    chk("rst_x", int'(x), 300);
    chk("rst_y", int'(y), 300);
    chk("rst_estado", int'(estado), 0);
    chk("rst_dir", int'(direcao), 0);
    chk("rst_tick", int'(tick), 0);
    model_reset();
    @(negedge CLOCK_50);
    resetInimigo = 1'b0;
  endtask

  initial begin
    int guard, x0, v;
    @(negedge CLOCK_50);
    do_reset(0, 0);
    chk("largura", int'(largura), 30);
    chk("altura", int'(altura), 30);

    // pause for 5 ticks' worth of cycles
    for (int i = 0; i < 5 * TD; i++) step(1'b1, i == 7);
    chk("pause_x", int'(x), 300);
    chk("pause_estado", int'(estado), 0);

    // patrol right to the wall and bounce
    run_ticks(10);
    chk("patrol_x320", int'(x), 320);
    guard = 0;
    while (mx != 608 && guard < 2000) begin step(1'b0, 1'b0); guard++; end
    chk("patrol_reach608", mx, 608);
    run_ticks(1);
    chk("wall_x", int'(x), 610);
    chk("wall_dir", int'(direcao), 1);
    run_ticks(1);
    chk("back_x", int'(x), 608);

    // chase toward (310,305)
    do_reset(310, 305);
    run_ticks(1);
    chk("chase_enter", int'(estado), 1);
    chk("chase_enter_x", int'(x), 300);
    run_ticks(5);
    chk("chase_x", int'(x), 310);
    chk("chase_y", int'(y), 305);
    run_ticks(2);
    chk("chase_hold_x", int'(x), 310);
    jogador_x = '0; jogador_y = '0;
    run_ticks(1);
    chk("chase_exit", int'(estado), 0);

    // hit stun and reload
    x0 = mx;
    step(1'b0, 1'b1);
    chk("stun_enter", int'(estado), 2);
    run_ticks(2);
    chk("stun_hold", int'(estado), 2);
    chk("stun_frozen_x", int'(x), x0);
    run_ticks(1);
    chk("stun_exit", int'(estado), 0);
    step(1'b0, 1'b1);
    run_ticks(2);
    step(1'b0, 1'b1);
    run_ticks(2);
    chk("stun_reload", int'(estado), 2);
    run_ticks(1);
    chk("stun_reload_exit", int'(estado), 0);

    // collision on the tick cycle while chasing; collision under pause
    do_reset(350, 350);
    run_ticks(2);
    chk("sim_chasing", int'(estado), 1);
    guard = 0;
    while (mcyc != TD - 1 && guard < 2 * TD) begin step(1'b0, 1'b0); guard++; end
    x0 = mx;
    step(1'b0, 1'b1);
    chk("sim_stun", int'(estado), 2);
    chk("sim_nostep", int'(x), x0);
    do_reset(350, 350);
    step(1'b1, 1'b1);
    chk("pause_col", int'(estado), 0);

    // randomized run
    for (int i = 0; i < 3000; i++) begin
      if (i % 37 == 0) begin
        if ($urandom_range(0, 3) == 0) begin
          jogador_x = 10'($urandom_range(0, 1023));
          jogador_y = 10'($urandom_range(0, 1023));
        end else begin
          v = mx + int'($urandom_range(0, 300)) - 150;
          jogador_x = 10'(v < 0 ? 0 : v);
          v = my + int'($urandom_range(0, 300)) - 150;
          jogador_y = 10'(v < 0 ? 0 : v);
        end
      end
      step($urandom_range(0, 9) == 0, $urandom_range(0, 59) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
